// File: rtl/serial_rcs.sv
// -----------------------------------------------------------------------------
// serial_rcs -- bit-serial ripple-borrow subtractor
//
// Purpose:
//   Computes diff = (a - b - bin) mod 2^WIDTH one bit per clock, LSB first.
//   It is the subtracting counterpart of the serial ripple-carry adder.
//   Operands are captured when start is accepted. WIDTH clock edges later the
//   result appears on diff/bout together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 4
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request, sampled only while busy=0
//   a      in   [WIDTH] minuend, captured on accept
//   b      in   [WIDTH] subtrahend, captured on accept
//   bin    in   borrow-in, captured on accept
//   diff   out  [WIDTH] result, held until the next completion or reset
//   bout   out  borrow-out (a < b + bin, unsigned), held with diff
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse, diff/bout valid
//   ovf    out  (only with SERIAL_RCS_OVF_EN) two's-complement overflow,
//               updated and held together with diff
//
// Optional feature macro: SERIAL_RCS_OVF_EN
// -----------------------------------------------------------------------------
module serial_rcs #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
`ifdef SERIAL_RCS_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    // Counter only has to count 0..WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;      // minuend shift register (shifts right)
    logic [WIDTH-1:0] r_b;      // subtrahend shift register (shifts right)
    logic [WIDTH-1:0] r_res;    // partial result, new bits enter at the MSB
    logic             r_br;     // running borrow
    logic [CW-1:0]    r_cnt;    // index of the bit processed on the next edge
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_RCS_OVF_EN
    logic             r_ovf;
`endif

    // Full subtractor on the current LSBs.
    logic w_x;
    logic w_y;
    logic w_d;
    logic w_brout;
    logic [WIDTH-1:0] w_res_next;

    assign w_x     = r_a[0];
    assign w_y     = r_b[0];
    assign w_d     = w_x ^ w_y ^ r_br;
    assign w_brout = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);

    // After WIDTH shifts the first (LSB) result bit has reached position 0.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_RCS_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            // done is a pulse: cleared every edge unless a completion sets it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_brout;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_brout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
`ifdef SERIAL_RCS_OVF_EN
                        // On the last bit the LSBs are the operand sign bits and
                        // w_d is the result sign bit: overflow when the operand
                        // signs differ and the result sign differs from a's.
                        r_ovf   <= (w_x != w_y) && (w_d != w_x);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SERIAL_RCS_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_rcs.sv
module tb_serial_rcs;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_RCS_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_rcs #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef SERIAL_RCS_OVF_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance past the next rising edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait up to a bounded number of edges for done; returns edges waited (0 = timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tbin, input logic [WIDTH-1:0] ed, input logic eb);
        int lat;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(lat);
        chk("done_latency", 32'(lat), 32'(WIDTH));
        chk("diff", 32'(diff), 32'(ed));
        chk("bout", 32'(bout), 32'(eb));
        chk("busy_on_done", 32'(busy), 32'd0);
        step();
        chk("done_falls", 32'(done), 32'd0);
        chk("diff_holds", 32'(diff), 32'(ed));
    endtask

    initial begin
        int lat;
        int pulses;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Basic operations
        run_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0);
        run_op(4'd3, 4'd5, 1'b0, 4'd14, 1'b1);
        run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        run_op(4'd15, 4'd15, 1'b0, 4'd0, 1'b0);

        // Busy rejection: second start at E2 ignored
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        step();                    // E0
        start = 1'b0;
        step();                    // E1
        a = 4'd1; b = 4'd1; start = 1'b1;
        step();                    // E2 (ignored)
        start = 1'b0;
        chk("busy_rej_diff_unchanged", 32'(diff), 32'd0);
        step();                    // E3
        chk("busy_rej_no_early_done", 32'(done), 32'd0);
        step();                    // E4
        chk("busy_rej_done", 32'(done), 32'd1);
        chk("busy_rej_diff", 32'(diff), 32'd5);
        pulses = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            step();
            if (done) pulses++;
        end
        chk("busy_rej_no_second_done", 32'(pulses), 32'd0);
        chk("busy_rej_busy_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high
        a = 4'd10; b = 4'd3; bin = 1'b0; start = 1'b1;
        step();                    // accept
        wait_done(lat);
        chk("b2b_first_latency", 32'(lat), 32'(WIDTH));
        chk("b2b_first_diff", 32'(diff), 32'd7);
        chk("b2b_first_bout", 32'(bout), 32'd0);
        a = 4'd2; b = 4'd6;        // change inputs on the done cycle
        step();                    // accepted with zero idle cycles
        chk("b2b_second_accept", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_second_latency", 32'(lat), 32'(WIDTH));
        chk("b2b_second_diff", 32'(diff), 32'd12);
        chk("b2b_second_bout", 32'(bout), 32'd1);
        step();

        // Reset mid-operation
        a = 4'd12; b = 4'd1; bin = 1'b0; start = 1'b1;
        step();                    // E0
        start = 1'b0;
        step();                    // E1
        rst = 1'b1;
        step();                    // E2 with reset
        rst = 1'b0;
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        pulses = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            step();
            if (done) pulses++;
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        run_op(4'd6, 4'd6, 1'b0, 4'd0, 1'b0);

        // Reset and start on the same edge: reset wins
        a = 4'd9; b = 4'd1; start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            step();
            if (done) pulses++;
        end
        chk("rst_start_no_done", 32'(pulses), 32'd0);

`ifdef SERIAL_RCS_OVF_EN
        chk("ovf_reset", 32'(ovf), 32'd0);
        run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0);
        chk("ovf_clear", 32'(ovf), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
